vx_warp_scheduler: RTL and testbench
====================================

Name: vx_warp_scheduler

Overview:
Multi-warp fetch scheduler: holds per-warp PC, thread mask and active state for NW warps. Each cycle it selects one eligible warp round-robin and presents its PC and thread mask to fetch. Control updates arrive from execute: jal/branch redirect, thread-mask change, warp spawn and warp halt. It sits ahead of fetch and replaces per-warp PC tracking with a shared, arbitrated instance.

Parameters:
NW, 4, number of warps (power of two, ≥2)
NT, 4, threads per warp
PC_RESET, 32'h0, warp 0 start PC

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
stall  in  1  fetch back-pressure; no issue, PCs hold
in_jal  in  1  jal redirect valid
in_jal_warp  in  log2(NW)  jal target warp
in_jal_dest  in  32  jal destination
in_branch_dir  in  1  taken branch redirect valid
in_branch_warp  in  log2(NW)  branch target warp
in_branch_dest  in  32  branch destination
in_change_mask  in  1  thread-mask update valid
in_mask_warp  in  log2(NW)  mask target warp
in_thread_mask  in  NT  new thread mask
in_wspawn  in  1  spawn all inactive warps
in_wspawn_pc  in  32  spawn PC
in_whalt  in  1  halt request
in_whalt_warp  in  log2(NW)  warp to deactivate
out_issue  out  1  fetch request valid this cycle
out_warp_num  out  log2(NW)  selected warp
out_PC  out  32  PC for selected warp
out_valid  out  NT  thread mask for selected warp; all-zero when !out_issue
out_active  out  NW  per-warp active flags

Behaviour:
- Reset (reset low, async):
  - warp 0: active, mask = 1 (lane 0 only), pc = PC_RESET.
  - Other warps: inactive, mask 0, pc 0.
  - last_grant = NW-1.
  - out_issue forced 0 while reset is low.
- Per-warp state: pc[31:0], mask[NT-1:0], active.
- Eligibility: active && mask != 0 && not halted this cycle.
- Arbitration (combinational): rotating priority starting at last_grant+1 mod NW; first eligible warp wins.
  - out_issue = any eligible && !stall.
- Same-cycle bypass for the selected warp, applied to outputs:
  - jal targeting it: out_PC = in_jal_dest.
  - Else taken branch targeting it: out_PC = in_branch_dest.
  - Else out_PC = pc[sel].
  - out_valid = in_thread_mask if in_change_mask targets it, else mask[sel]; 0 when !out_issue.
  - A mask change to zero makes the warp ineligible in that same cycle.
- Clock edge, per warp w, first match wins:
  1. whalt on w: active ← 0.
  2. w issued: pc ← bypassed PC + 4.
  3. Redirect on w (not issued): pc ← dest; jal beats branch.
  4. Otherwise pc holds.
- Mask update applies regardless of stall.
- On issue, last_grant ← sel. Stalled cycles leave last_grant unchanged.
- wspawn: every inactive warp w≠0 gets active ← 1, pc ← in_wspawn_pc, mask ← 1. Active warps are unaffected.
- Redirects or mask changes targeting an inactive warp update stored state but cause no issue.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFFFFFC + 4 = 0).
- All warps halted: out_issue = 0 until wspawn or reset. Warp 0 can only be revived by reset.
- Latency: selection and PC are combinational from state plus bypass, 0 cycles. State updates take 1 cycle.

Decomposition:
- Shared package vx_sched_pkg:
  - NW, NT defaults.
  - WARP_W = $clog2(NW).
  - PC_INCR = 32'h4.
  - Reset mask constant (lane 0).
  - Per-warp state struct {pc, mask, active}.
- Sub-module vx_rr_arbiter:
  - Inputs: NW request vector, last_grant.
  - Outputs: one-hot grant, encoded index, any_grant.
  - Purely combinational rotating-priority search.

Test Plan:
- Reset, no stimulus → warp 0 issues PC 0x0, 0x4, 0x8 on consecutive cycles; out_valid=4'b0001; out_active=4'b0001.
- wspawn pc=0x100 at cycle 2 (warp 0 at 0x8) → issue order: w1@0x100, w2@0x100, w3@0x100, w0@0xC, w1@0x104.
- Stall held 3 cycles mid-sequence → out_issue=0, out_valid=0, PCs and last_grant frozen; same warp/PC issues on release.
- Branch dir=1, dest=0x200, targeting currently selected warp → out_PC=0x200 same cycle; that warp's next issue 0x204. jal=0x300 and branch=0x200 same warp same cycle → 0x300.
- change_mask warp 2 to 0 → w2 skipped in rotation; change_mask warp 1 to 4'b1010 when w1 selected → out_valid=4'b1010 same cycle.
- whalt all active warps → out_issue=0 indefinitely; async reset low mid-run → out_issue=0 immediately; after release w0 issues PC_RESET.

Source files
------------

// File: rtl/vx_sched_pkg.sv
// Shared types and constants for the multi-warp fetch scheduler.
package vx_sched_pkg;

    localparam int NUM_WARPS   = 4;
    localparam int NUM_THREADS = 4;
    localparam int WARP_W      = $clog2(NUM_WARPS);

    localparam logic [31:0]            PC_INCR    = 32'h4;
    localparam logic [NUM_THREADS-1:0] RESET_MASK = NUM_THREADS'(1);

    // The mask field is sized by NUM_THREADS, so the scheduler's NT must match it.
    typedef struct packed {
        logic [31:0]            pc;
        logic [NUM_THREADS-1:0] mask;
        logic                   active;
    } warp_state_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts one past last_grant.
module vx_rr_arbiter #(
    parameter int NW = 4,
    parameter int WW = $clog2(NW)
) (
    input  logic [NW-1:0] req,
    input  logic [WW-1:0] last_grant,
    output logic [NW-1:0] grant,
    output logic [WW-1:0] grant_idx,
    output logic          any_grant
);

    always_comb begin
        logic [WW-1:0] cand;
        cand      = '0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        // NW is a power of two, so the index wraps naturally at WW bits.
        for (int i = 0; i < NW; i++) begin
            cand = last_grant + WW'(i + 1);
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vx_warp_scheduler.sv
// Per-warp PC/mask/active tracking with round-robin fetch selection and same-cycle redirect bypass.
module vx_warp_scheduler
    import vx_sched_pkg::*;
#(
    parameter int          NW       = NUM_WARPS,
    parameter int          NT       = NUM_THREADS,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  in_jal,
    input  logic [$clog2(NW)-1:0] in_jal_warp,
    input  logic [31:0]           in_jal_dest,
    input  logic                  in_branch_dir,
    input  logic [$clog2(NW)-1:0] in_branch_warp,
    input  logic [31:0]           in_branch_dest,
    input  logic                  in_change_mask,
    input  logic [$clog2(NW)-1:0] in_mask_warp,
    input  logic [NT-1:0]         in_thread_mask,
    input  logic                  in_wspawn,
    input  logic [31:0]           in_wspawn_pc,
    input  logic                  in_whalt,
    input  logic [$clog2(NW)-1:0] in_whalt_warp,
    output logic                  out_issue,
    output logic [$clog2(NW)-1:0] out_warp_num,
    output logic [31:0]           out_PC,
    output logic [NT-1:0]         out_valid,
    output logic [NW-1:0]         out_active
);

    localparam int WW = $clog2(NW);

    warp_state_t   st [NW];
    logic [NT-1:0] mask_eff [NW];
    logic [31:0]   pc_byp [NW];
    logic [NW-1:0] eligible;
    logic [NW-1:0] grant;
    logic [WW-1:0] sel;
    logic [WW-1:0] last_grant;
    logic          any_grant;

    // Effective mask and PC fold in this cycle's execute updates before arbitration.
    always_comb begin
        for (int w = 0; w < NW; w++) begin
            mask_eff[w] = (in_change_mask && in_mask_warp == WW'(w)) ? in_thread_mask : st[w].mask;
            eligible[w] = st[w].active && (mask_eff[w] != '0) &&
                          !(in_whalt && in_whalt_warp == WW'(w));
            if (in_jal && in_jal_warp == WW'(w))
                pc_byp[w] = in_jal_dest;
            else if (in_branch_dir && in_branch_warp == WW'(w))
                pc_byp[w] = in_branch_dest;
            else
                pc_byp[w] = st[w].pc;
        end
    end

    vx_rr_arbiter #(.NW(NW)) u_arb (
        .req        (eligible),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (sel),
        .any_grant  (any_grant)
    );

    // Handshake: out_issue is the fetch valid and stall is the inverse of ready; a warp is
    // consumed (PC advances, pointer rotates) only on a cycle where out_issue is high.
    assign out_issue    = any_grant && !stall && reset;
    assign out_warp_num = sel;
    assign out_PC       = pc_byp[sel];
    assign out_valid    = out_issue ? mask_eff[sel] : '0;

    always_comb begin
        out_active = '0;
        for (int w = 0; w < NW; w++) out_active[w] = st[w].active;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= WW'(NW - 1);
            for (int w = 0; w < NW; w++) begin
                st[w].pc     <= (w == 0) ? PC_RESET : 32'h0;
                st[w].mask   <= (w == 0) ? RESET_MASK : '0;
                st[w].active <= (w == 0);
            end
        end else begin
            if (out_issue) last_grant <= sel;
            for (int w = 0; w < NW; w++) begin
                if (in_whalt && in_whalt_warp == WW'(w))
                    st[w].active <= 1'b0;
                else if (out_issue && grant[w])
                    st[w].pc <= pc_byp[w] + PC_INCR;
                else if (in_jal && in_jal_warp == WW'(w))
                    st[w].pc <= in_jal_dest;
                else if (in_branch_dir && in_branch_warp == WW'(w))
                    st[w].pc <= in_branch_dest;

                if (in_change_mask && in_mask_warp == WW'(w))
                    st[w].mask <= in_thread_mask;

                // Spawn only revives warps 1..NW-1; warp 0 comes back through reset.
                if (in_wspawn && !st[w].active && w != 0) begin
                    st[w].active <= 1'b1;
                    st[w].pc     <= in_wspawn_pc;
                    st[w].mask   <= RESET_MASK;
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_warp_scheduler.sv
// Directed bench for vx_warp_scheduler: issue order, spawn, stall, redirects, masks, halt, reset.
module tb_vx_warp_scheduler;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        in_jal;
    logic [1:0]  in_jal_warp;
    logic [31:0] in_jal_dest;
    logic        in_branch_dir;
    logic [1:0]  in_branch_warp;
    logic [31:0] in_branch_dest;
    logic        in_change_mask;
    logic [1:0]  in_mask_warp;
    logic [3:0]  in_thread_mask;
    logic        in_wspawn;
    logic [31:0] in_wspawn_pc;
    logic        in_whalt;
    logic [1:0]  in_whalt_warp;
    logic        out_issue;
    logic [1:0]  out_warp_num;
    logic [31:0] out_PC;
    logic [3:0]  out_valid;
    logic [3:0]  out_active;

    int total = 0;
    int bad   = 0;

    vx_warp_scheduler #(.NW(4), .NT(4), .PC_RESET(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .in_jal         (in_jal),
        .in_jal_warp    (in_jal_warp),
        .in_jal_dest    (in_jal_dest),
        .in_branch_dir  (in_branch_dir),
        .in_branch_warp (in_branch_warp),
        .in_branch_dest (in_branch_dest),
        .in_change_mask (in_change_mask),
        .in_mask_warp   (in_mask_warp),
        .in_thread_mask (in_thread_mask),
        .in_wspawn      (in_wspawn),
        .in_wspawn_pc   (in_wspawn_pc),
        .in_whalt       (in_whalt),
        .in_whalt_warp  (in_whalt_warp),
        .out_issue      (out_issue),
        .out_warp_num   (out_warp_num),
        .out_PC         (out_PC),
        .out_valid      (out_valid),
        .out_active     (out_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        stall          = 1'b0;
        in_jal         = 1'b0;
        in_jal_warp    = 2'd0;
        in_jal_dest    = 32'h0;
        in_branch_dir  = 1'b0;
        in_branch_warp = 2'd0;
        in_branch_dest = 32'h0;
        in_change_mask = 1'b0;
        in_mask_warp   = 2'd0;
        in_thread_mask = 4'b0;
        in_wspawn      = 1'b0;
        in_wspawn_pc   = 32'h0;
        in_whalt       = 1'b0;
        in_whalt_warp  = 2'd0;
    endtask

    task automatic test_reset();
        logic [31:0] ep;
        reset = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_issue !== 1'b0 || out_valid !== 4'b0) begin
            bad++;
            $display("FAIL reset_outputs: got issue=%0d valid=%b, want issue=0 valid=0000", out_issue, out_valid);
        end
        total++;
        if (out_active !== 4'b0001) begin
            bad++;
            $display("FAIL reset_active: got %b want 0001", out_active);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle();
            #1;
            ep = 32'(i * 4);
            total++;
            if ({out_issue, out_warp_num, out_PC, out_valid} !== {1'b1, 2'd0, ep, 4'b0001}) begin
                bad++;
                $display("FAIL reset_issue[%0d]: got issue=%0d warp=%0d pc=%h valid=%b, want 1 0 %h 0001",
                         i, out_issue, out_warp_num, out_PC, out_valid, ep);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_spawn();
        logic [1:0]  ew;
        logic [31:0] ep;
        idle();
        in_wspawn    = 1'b1;
        in_wspawn_pc = 32'h100;
        #1;
        total++;
        if ({out_issue, out_warp_num, out_PC, out_valid} !== {1'b1, 2'd0, 32'h8, 4'b0001}) begin
            bad++;
            $display("FAIL spawn_cycle: got issue=%0d warp=%0d pc=%h valid=%b, want 1 0 00000008 0001",
                     out_issue, out_warp_num, out_PC, out_valid);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (out_active !== 4'b1111) begin
            bad++;
            $display("FAIL spawn_active: got %b want 1111", out_active);
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0: begin ew = 2'd1; ep = 32'h100; end
                1: begin ew = 2'd2; ep = 32'h100; end
                2: begin ew = 2'd3; ep = 32'h100; end
                3: begin ew = 2'd0; ep = 32'hC;   end
                default: begin ew = 2'd1; ep = 32'h104; end
            endcase
            #1;
            total++;
            if ({out_issue, out_warp_num, out_PC, out_valid} !== {1'b1, ew, ep, 4'b0001}) begin
                bad++;
                $display("FAIL spawn_order[%0d]: got issue=%0d warp=%0d pc=%h valid=%b, want 1 %0d %h 0001",
                         i, out_issue, out_warp_num, out_PC, out_valid, ew, ep);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            idle();
            stall = (i < 3);
            #1;
            total++;
            if ({out_issue, out_warp_num, out_PC, out_valid} !==
                {(i == 3), 2'd2, 32'h104, ((i == 3) ? 4'b0001 : 4'b0000)}) begin
                bad++;
                $display("FAIL stall[%0d]: got issue=%0d warp=%0d pc=%h valid=%b, want issue=%0d warp=2 pc=00000104",
                         i, out_issue, out_warp_num, out_PC, out_valid, (i == 3));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        logic [1:0]  ew;
        logic [31:0] ep;
        for (int i = 0; i < 8; i++) begin
            idle();
            case (i)
                0: begin in_branch_dir = 1'b1; in_branch_warp = 2'd3; in_branch_dest = 32'h200;
                         ew = 2'd3; ep = 32'h200; end
                1: begin ew = 2'd0; ep = 32'h10;  end
                2: begin ew = 2'd1; ep = 32'h108; end
                3: begin ew = 2'd2; ep = 32'h108; end
                4: begin ew = 2'd3; ep = 32'h204; end
                5: begin in_jal = 1'b1; in_jal_warp = 2'd0; in_jal_dest = 32'h300;
                         in_branch_dir = 1'b1; in_branch_warp = 2'd0; in_branch_dest = 32'h200;
                         ew = 2'd0; ep = 32'h300; end
                6: begin in_branch_dir = 1'b1; in_branch_warp = 2'd2; in_branch_dest = 32'h400;
                         ew = 2'd1; ep = 32'h10C; end
                default: begin ew = 2'd2; ep = 32'h400; end
            endcase
            #1;
            total++;
            if ({out_issue, out_warp_num, out_PC, out_valid} !== {1'b1, ew, ep, 4'b0001}) begin
                bad++;
                $display("FAIL redirect[%0d]: got issue=%0d warp=%0d pc=%h valid=%b, want 1 %0d %h 0001",
                         i, out_issue, out_warp_num, out_PC, out_valid, ew, ep);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mask_and_wrap();
        logic [1:0]  ew;
        logic [31:0] ep;
        logic [3:0]  ev;
        for (int i = 0; i < 12; i++) begin
            idle();
            ev = 4'b0001;
            case (i)
                0:  begin in_change_mask = 1'b1; in_mask_warp = 2'd2; in_thread_mask = 4'b0;
                          ew = 2'd3; ep = 32'h208; end
                1:  begin ew = 2'd0; ep = 32'h304; end
                2:  begin ew = 2'd1; ep = 32'h110; end
                3:  begin ew = 2'd3; ep = 32'h20C; end
                4:  begin ew = 2'd0; ep = 32'h308; end
                5:  begin in_change_mask = 1'b1; in_mask_warp = 2'd1; in_thread_mask = 4'b1010;
                          ew = 2'd1; ep = 32'h114; ev = 4'b1010; end
                6:  begin in_change_mask = 1'b1; in_mask_warp = 2'd3; in_thread_mask = 4'b0;
                          ew = 2'd0; ep = 32'h30C; end
                7:  begin ew = 2'd1; ep = 32'h118; ev = 4'b1010; end
                8:  begin in_jal = 1'b1; in_jal_warp = 2'd1; in_jal_dest = 32'hFFFF_FFFC;
                          ew = 2'd0; ep = 32'h310; end
                9:  begin ew = 2'd1; ep = 32'hFFFF_FFFC; ev = 4'b1010; end
                10: begin ew = 2'd0; ep = 32'h314; end
                default: begin ew = 2'd1; ep = 32'h0; ev = 4'b1010; end
            endcase
            #1;
            total++;
            if ({out_issue, out_warp_num, out_PC, out_valid} !== {1'b1, ew, ep, ev}) begin
                bad++;
                $display("FAIL mask_wrap[%0d]: got issue=%0d warp=%0d pc=%h valid=%b, want 1 %0d %h %b",
                         i, out_issue, out_warp_num, out_PC, out_valid, ew, ep, ev);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 4; i++) begin
            idle();
            in_whalt      = 1'b1;
            in_whalt_warp = (i == 0) ? 2'd1 : (i == 1) ? 2'd0 : (i == 2) ? 2'd2 : 2'd3;
            #1;
            total++;
            if (i == 0) begin
                if ({out_issue, out_warp_num, out_PC, out_valid} !== {1'b1, 2'd0, 32'h318, 4'b0001}) begin
                    bad++;
                    $display("FAIL halt_first: got issue=%0d warp=%0d pc=%h valid=%b, want 1 0 00000318 0001",
                             out_issue, out_warp_num, out_PC, out_valid);
                end
            end else if (out_issue !== 1'b0 || out_valid !== 4'b0) begin
                bad++;
                $display("FAIL halt[%0d]: got issue=%0d valid=%b, want 0 0000", i, out_issue, out_valid);
            end
            @(negedge clk);
        end
        idle();
        #1;
        total++;
        if (out_active !== 4'b0000) begin
            bad++;
            $display("FAIL halt_active: got %b want 0000", out_active);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_issue !== 1'b0) begin
                bad++;
                $display("FAIL halt_idle[%0d]: got issue=%0d want 0", i, out_issue);
            end
            @(negedge clk);
            #1;
        end
        in_wspawn    = 1'b1;
        in_wspawn_pc = 32'h500;
        #1;
        total++;
        if (out_issue !== 1'b0) begin
            bad++;
            $display("FAIL respawn_cycle: got issue=%0d want 0", out_issue);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (out_active !== 4'b1110) begin
            bad++;
            $display("FAIL respawn_active: got %b want 1110", out_active);
        end
        total++;
        if ({out_issue, out_warp_num, out_PC, out_valid} !== {1'b1, 2'd1, 32'h500, 4'b0001}) begin
            bad++;
            $display("FAIL respawn_issue: got issue=%0d warp=%0d pc=%h valid=%b, want 1 1 00000500 0001",
                     out_issue, out_warp_num, out_PC, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        idle();
        reset = 1'b0;
        #1;
        total++;
        if (out_issue !== 1'b0 || out_active !== 4'b0001) begin
            bad++;
            $display("FAIL async_reset: got issue=%0d active=%b, want 0 0001", out_issue, out_active);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle();
            #1;
            total++;
            if ({out_issue, out_warp_num, out_PC, out_valid} !== {1'b1, 2'd0, 32'(i * 4), 4'b0001}) begin
                bad++;
                $display("FAIL after_reset[%0d]: got issue=%0d warp=%0d pc=%h valid=%b, want 1 0 %h 0001",
                         i, out_issue, out_warp_num, out_PC, out_valid, 32'(i * 4));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_stall();
        test_redirect();
        test_mask_and_wrap();
        test_halt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
